adder_arbiter: RTL and testbench

//   Shares one WIDTH-bit adder among N_REQ requesters (PC increment, branch target, AGU, ...).

---
 rtl/adder_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/adder_arbiter.sv | 172 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder_arbiter slice: requester index type,
// result-stage state encoding and the round-robin pointer advance function.
package adder_arb_pkg;

  // Largest supported requester count; the index type is sized to hold it.
  localparam int N_REQ_MAX = 8;

  typedef logic [2:0] req_idx_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Next round-robin start position: one past idx, wrapping at n_req.
  function automatic req_idx_t rr_next(input req_idx_t idx, input int n_req);
    req_idx_t nxt;
    if (int'(idx) >= n_req - 1) begin
      nxt = 3'd0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, searching upward modulo N_REQ. Returns a one-hot grant, the
// granted index and a flag telling whether anything was granted.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_idx,
  output logic             gnt_any
);

  logic [2*N_REQ-1:0] req_dbl_s;
  logic [2*N_REQ-1:0] gnt_dbl_s;
  logic [N_REQ-1:0]   rot_req_s;
  logic [N_REQ-1:0]   rot_gnt_s;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl_s = {req, req} >> ptr;
    rot_req_s = req_dbl_s[N_REQ-1:0];
    rot_gnt_s = {N_REQ{1'b0}};
    gnt_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rot_req_s[k] && !gnt_any) begin
        rot_gnt_s[k] = 1'b1;
        gnt_any      = 1'b1;
      end else begin
      end
    end
    gnt_dbl_s = {rot_gnt_s, rot_gnt_s} << ptr;
    gnt       = gnt_dbl_s[2*N_REQ-1 -: N_REQ];
    gnt_idx   = 3'd0;
    for (int m = 0; m < N_REQ; m++) begin
      if (gnt[m]) begin
        gnt_idx = 3'(m);
      end else begin
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one WIDTH-bit adder among N_REQ requesters with round-robin grants
// and a single registered result stage (1-cycle latency, full throughput
// while the owning consumer drains every cycle).
// Optional build macro: ADDER_ARB_STATS_EN adds stat_grants / stat_stalls.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_carry
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [31:0]            stat_grants,
  output logic [31:0]            stat_stalls
`endif
);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic [N_REQ-1:0] arb_gnt_s;
  logic [2:0]       arb_idx_s;
  logic             arb_any_s;
  logic             drain_s;
  logic             free_s;
  logic             grant_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH:0]   sum_s;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .gnt_any (arb_any_s)
  );

  // Stage is free when empty or when its owner takes the result this cycle;
  // grants are suppressed entirely while reset is asserted.
  always_comb begin
    drain_s = |(rsp_valid_q & rsp_ready);
    free_s  = (state_q == ST_EMPTY) || drain_s;
    if (!rst && free_s && arb_any_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    req_ready = grant_s ? arb_gnt_s : {N_REQ{1'b0}};
  end

  // Select the granted requester's operands and form the carry-extended sum.
  always_comb begin
    a_sel_s = {WIDTH{1'b0}};
    b_sel_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt_s[i]) begin
        a_sel_s = req_a[i*WIDTH +: WIDTH];
        b_sel_s = req_b[i*WIDTH +: WIDTH];
      end else begin
      end
    end
    sum_s = {1'b0, a_sel_s} + {1'b0, b_sel_s};
  end

  // Result-stage FSM: load on grant, release on drain, hold otherwise.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    case (state_q)
      ST_EMPTY: begin
        if (grant_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (grant_s) begin
          state_d = ST_FULL;
        end else if (drain_s) begin
          state_d     = ST_EMPTY;
          rsp_valid_d = {N_REQ{1'b0}};
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        rsp_valid_d = {N_REQ{1'b0}};
      end
    endcase
    if (grant_s) begin
      rsp_valid_d = arb_gnt_s;
      rsp_data_d  = sum_s[WIDTH-1:0];
      rsp_carry_d = sum_s[WIDTH];
      ptr_d       = rr_next(arb_idx_s, N_REQ);
    end else begin
    end
  end

  // State, pointer and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ptr_q       <= 3'd0;
      rsp_valid_q <= {N_REQ{1'b0}};
      rsp_data_q  <= {WIDTH{1'b0}};
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;

`ifdef ADDER_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Count grants, and cycles where someone asked but nobody was granted.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stalls_d = stat_stalls_q;
    if (grant_s) begin
      stat_grants_d = stat_grants_q + 32'd1;
    end else if (|req_valid) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end else begin
    end
  end

  // Statistics registers, cleared by reset, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants_q <= 32'd0;
      stat_stalls_q <= 32'd0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: a transaction-level model (pending
// result slot + round-robin pointer) is compared against the DUT on every
// falling edge, plus hand-computed directed checks.
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_carry;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0]    stat_grants;
  logic [31:0]    stat_stalls;
`endif

  adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: one optional pending result and a round-robin pointer.
  bit           m_valid = 1'b0;
  int           m_owner = 0;
  logic [W-1:0] m_data  = '0;
  bit           m_carry = 1'b0;
  int           m_ptr   = 0;
  logic [31:0]  m_grants = '0;
  logic [31:0]  m_stalls = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Index the model would grant this cycle, or -1 for no grant.
  function automatic int exp_grant();
    bit free;
    if (rst) return -1;
    free = !m_valid || (rsp_ready[m_owner] == 1'b1);
    if (!free) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // Model update on each rising edge (inputs are stable here).
  always @(posedge clk) begin
    int g;
    logic [W:0] s;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_carry = 1'b0; m_ptr = 0;
      m_grants = '0; m_stalls = '0;
    end else begin
      g = exp_grant();
      if (g >= 0) begin
        s = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
        m_valid = 1'b1; m_owner = g;
        m_data = s[W-1:0]; m_carry = s[W];
        m_ptr = (g + 1) % N;
        m_grants = m_grants + 32'd1;
      end else begin
        if (m_valid && rsp_ready[m_owner]) m_valid = 1'b0;
        if (|req_valid) m_stalls = m_stalls + 32'd1;
      end
    end
  end

  // Compare process: DUT versus model on every falling edge.
  always @(negedge clk) begin
    logic [N-1:0] er, ev;
    int g;
    if (chk_en) begin
      g = exp_grant();
      er = '0; ev = '0;
      if (g >= 0) er[g] = 1'b1;
      if (m_valid) ev[m_owner] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("rsp_data", 64'(rsp_data), 64'(m_data));
      chk("rsp_carry", 64'(rsp_carry), 64'(m_carry));
`ifdef ADDER_ARB_STATS_EN
      chk("stat_grants", 64'(stat_grants), 64'(m_grants));
      chk("stat_stalls", 64'(stat_stalls), 64'(m_stalls));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 4'b0000;
    req_a = '0; req_b = '0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_data", 64'(rsp_data), 64'h0);
    chk("reset_rsp_carry", 64'(rsp_carry), 64'h0);
    tick();

    // Single request: 5 + 7.
    rst = 1'b0; req_valid = 4'b0001; rsp_ready = 4'b1111;
    req_a[0*W +: W] = 32'd5; req_b[0*W +: W] = 32'd7;
    @(negedge clk);
    chk("single_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", 64'(rsp_valid), 64'h1);
    chk("single_data", 64'(rsp_data), 64'd12);
    chk("single_carry", 64'(rsp_carry), 64'h0);
    tick();

    // Wrap: all-ones + 1 on requester 1 (pointer now at 1).
    req_valid = 4'b0010;
    req_a[1*W +: W] = 32'hFFFF_FFFF; req_b[1*W +: W] = 32'd1;
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("wrap_valid", 64'(rsp_valid), 64'h2);
    chk("wrap_data", 64'(rsp_data), 64'h0);
    chk("wrap_carry", 64'(rsp_carry), 64'h1);
    tick();
    rst = 1'b1;
    tick();

    // All four requesting, consumer always ready: 0,1,2,3,0,... no bubbles.
    rst = 1'b0; req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(16 * i + 1);
      req_b[i*W +: W] = 32'd100;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("rr_rsp_valid", 64'(rsp_valid), 64'(1 << ((k - 1) % 4)));
        chk("rr_rsp_data", 64'(rsp_data), 64'(101 + 16 * ((k - 1) % 4)));
      end
      tick();
    end

    // Backpressure: owner 3 holds off for 3 cycles; other ready bits ignored.
    rsp_ready = 4'b0111;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'h0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h8);
      chk("bp_rsp_data", 64'(rsp_data), 64'd149);
      tick();
    end
    rsp_ready = 4'b1111;
    @(negedge clk);
    chk("bp_resume", 64'(req_ready), 64'h1);
    tick();

    // Reset while FULL with everyone requesting.
    rst = 1'b1;
    @(negedge clk);
    chk("rst_full_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_full_valid", 64'(rsp_valid), 64'h0);
    chk("rst_first_grant", 64'(req_ready), 64'h1);
    tick();

`ifdef ADDER_ARB_STATS_EN
    // 10 grants then 3 blocked cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b0001; rsp_ready = 4'b1111;
    for (int k = 0; k < 10; k++) tick();
    rsp_ready = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("stats_grants", 64'(stat_grants), 64'd10);
    chk("stats_stalls", 64'(stat_stalls), 64'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("stats_clr_grants", 64'(stat_grants), 64'd0);
    chk("stats_clr_stalls", 64'(stat_stalls), 64'd0);
    tick();
`endif

    // Randomised traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = rnd_word();
        req_b[i*W +: W] = rnd_word();
      end
      tick();
    end

    rst = 1'b0; req_valid = 4'b0000;
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
